universal_deser: RTL and testbench
==================================

Name: universal_deser

Overview:
- Serial-in / parallel-out receiver; the receiving end of the 4-bit universal shift register's serial path.
- Accepts a framed serial bit stream, either MSB-first or LSB-first.
- Reassembles each frame into a DW-bit word and pulses valid when the word is ready.
- Sits between the shift-register datapath and downstream parallel consumers (display, compare logic).

Parameters:
- DW, 4, width of the reassembled word and frame length in bits (DW >= 2).
- CW, $clog2(DW)+1, bit-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  clock enable; when 0 all state holds and sin is not sampled.
- start  input  1  frame start; the cycle it is accepted carries bit 0 on sin.
- msb_first  input  1  bit order, captured when start is accepted (1 = MSB first).
- sin  input  1  serial data in.
- out  output  DW  last completed word; held until the next frame completes.
- valid  output  1  one-cycle pulse; out updated this cycle.
- busy  output  1  high while a frame is being collected (state SHIFT).

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, cnt=0, order=0, out=0, valid=0, busy=0.
- States: IDLE, SHIFT, DONE. All transitions require enable=1, except DONE->IDLE.
- Shift rule, MSB-first: shreg <= {shreg[DW-2:0], sin}.
- Shift rule, LSB-first: shreg <= {sin, shreg[DW-1:1]}.
- IDLE:
  - enable & start: capture order<=msb_first, shift in sin (bit 0), cnt<=1, go to SHIFT.
  - Otherwise: hold.
- SHIFT (busy=1):
  - enable=1: shift in sin, cnt<=cnt+1.
  - Last bit is when cnt==DW-1: load out with the assembled word including the current sin, go to DONE.
  - enable=0: full stall, no sample, cnt holds.
  - start is ignored in SHIFT.
  - msb_first changes are ignored until the next frame.
- DONE: valid=1 for exactly one cycle; next state IDLE unconditionally; start is ignored.
- Latency: start accepted at edge 0 with no stalls -> valid high in the cycle after edge DW-1; out stable from that cycle.
- Throughput: one frame per DW+1 cycles. Back-to-back start requires one IDLE cycle after DONE.
- Reset mid-frame: partial word discarded, out cleared to 0, no valid.
- Simultaneous start and enable=0 in IDLE: start not accepted; the bit is lost. The sender must hold start until enable=1.
- valid and busy are registered or pure state decodes; no combinational path from inputs to outputs.

Decomposition:
- universal_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} deser_state_t;
  - localparam DW_DEFAULT = 4;
  - the shared order constants MSB_FIRST=1'b1 and LSB_FIRST=1'b0.
- No sub-module: counter, shift register and FSM stay in a single module, with one always_ff for state and data and one always_comb for next state.

Test Plan:
- MSB-first, DW=4: start with sin=1, then sin=1,0,1 on consecutive enabled cycles -> out=4'hD, valid one cycle at cycle 4, busy high cycles 1-3.
- LSB-first: msb_first=0, sin sequence 1,0,1,1 -> out=4'hD; the same sequence MSB-first gives 4'hB.
- Stall: MSB-first 1,1,0,1 with enable=0 for 3 cycles after the second bit -> out=4'hD, valid delayed exactly 3 cycles, still a single pulse.
- Reset mid-frame: start frame 1,1,... then pull rst low after the second bit -> out=0, valid=0, state IDLE; a following frame 0,1,1,0 -> out=4'h6.
- start held high continuously: frames of 4'hA then 4'h5 -> two valid pulses 5 cycles apart, out=4'hA then 4'h5; start during SHIFT/DONE causes no corruption.
- msb_first toggled mid-frame: frame 1,0,0,0 started MSB-first, msb_first flips after bit 1 -> out=4'h8 (order latched at start).

Source files
------------

// File: rtl/universal_pkg.sv
// Shared types and constants for the universal shift-register receive path.
package universal_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} deser_state_t;

    localparam int DW_DEFAULT = 4;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/universal_deser.sv
// Framed serial-in / parallel-out receiver, MSB- or LSB-first.
module universal_deser
    import universal_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    localparam int CW = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          start,
    input  logic          msb_first,
    input  logic          sin,
    output logic [DW-1:0] out,
    output logic          valid,
    output logic          busy
);

    deser_state_t state_q, state_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [DW-1:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          order_q, order_d;

    logic [DW-1:0] sh_msb;
    logic [DW-1:0] sh_lsb;

    assign sh_msb = {shreg_q[DW-2:0], sin};
    assign sh_lsb = {sin, shreg_q[DW-1:1]};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        unique case (state_q)
            IDLE: begin
                if (enable && start) begin
                    order_d = msb_first;
                    shreg_d = (msb_first == LSB_FIRST) ? sh_lsb : sh_msb;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    // order is the value latched at start, not the live pin
                    shreg_d = (order_q == MSB_FIRST) ? sh_msb : sh_lsb;
                    if (cnt_q == CW'(DW - 1)) begin
                        out_d   = shreg_d;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            order_q <= LSB_FIRST;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

    assign out   = out_q;
    assign valid = (state_q == DONE);
    assign busy  = (state_q == SHIFT);

endmodule

// File: tb/tb_universal_deser.sv
// Self-checking bench for universal_deser: directed frames plus random traffic.
module tb_universal_deser;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          start = 1'b0;
    logic          msb_first = 1'b0;
    logic          sin = 1'b0;
    logic [DW-1:0] out;
    logic          valid;
    logic          busy;

    universal_deser #(.DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .start(start),
        .msb_first(msb_first),
        .sin(sin),
        .out(out),
        .valid(valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int last_valid = -1;
    int prev_valid = -1;

    // Behavioural model: collected bits of the current frame, in arrival order
    bit            m_q[$];
    bit            m_collect = 0;
    bit            m_valid = 0;
    bit            m_order = 0;
    logic [DW-1:0] m_out = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] w;
        if (!rst) begin
            m_q.delete();
            m_collect = 0;
            m_valid = 0;
            m_order = 0;
            m_out = '0;
        end else if (m_valid) begin
            m_valid = 0;
        end else if (!m_collect) begin
            if (enable && start) begin
                m_collect = 1;
                m_order = msb_first;
                m_q.delete();
                m_q.push_back(sin);
            end
        end else if (enable) begin
            m_q.push_back(sin);
            if (m_q.size() == DW) begin
                w = '0;
                for (int i = 0; i < DW; i++) begin
                    if (m_order) w[DW-1-i] = m_q[i];
                    else         w[i] = m_q[i];
                end
                m_out = w;
                m_collect = 0;
                m_valid = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_collect));
        if (valid) begin
            prev_valid = last_valid;
            last_valid = cyc;
        end
    endtask

    task automatic idle_inputs();
        enable = 1'b1;
        start = 1'b0;
        sin = 1'b0;
    endtask

    // Sends seq[3] first; after the last bit the DONE cycle is checked
    task automatic frame(input logic mf, input logic [3:0] seq,
                         input logic [3:0] exp, input string name);
        enable = 1'b1;
        start = 1'b1;
        msb_first = mf;
        sin = seq[3];
        cycle();
        start = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            sin = seq[i];
            cycle();
        end
        chk({name, "_valid"}, 32'(valid), 32'd1);
        chk({name, "_out"}, 32'(out), 32'(exp));
        idle_inputs();
        cycle();
        chk({name, "_pulse"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int t0;
        #2;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        cycle();
        #3;
        rst = 1'b1;
        idle_inputs();
        cycle();

        // MSB-first 1,1,0,1 with busy over cycles 1-3
        enable = 1'b1;
        start = 1'b1;
        msb_first = 1'b1;
        sin = 1'b1;
        cycle();
        chk("t1_busy1", 32'(busy), 32'd1);
        start = 1'b0;
        sin = 1'b1;
        cycle();
        chk("t1_busy2", 32'(busy), 32'd1);
        sin = 1'b0;
        cycle();
        chk("t1_busy3", 32'(busy), 32'd1);
        sin = 1'b1;
        cycle();
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_out", 32'(out), 32'hD);
        chk("t1_busy4", 32'(busy), 32'd0);
        idle_inputs();
        cycle();

        frame(1'b0, 4'b1011, 4'hD, "lsb");
        frame(1'b1, 4'b1011, 4'hB, "msb");

        // Stall for 3 cycles after the second bit
        enable = 1'b1;
        start = 1'b1;
        msb_first = 1'b1;
        sin = 1'b1;
        cycle();
        t0 = cyc;
        start = 1'b0;
        cycle();
        enable = 1'b0;
        sin = 1'b1;
        repeat (3) cycle();
        enable = 1'b1;
        sin = 1'b0;
        cycle();
        sin = 1'b1;
        cycle();
        chk("stall_lat", 32'(cyc - t0), 32'd6);
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_out", 32'(out), 32'hD);
        idle_inputs();
        cycle();
        chk("stall_pulse", 32'(valid), 32'd0);

        // Reset mid-frame
        enable = 1'b1;
        start = 1'b1;
        sin = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cycle();
        chk("rst_valid", 32'(valid), 32'd0);
        rst = 1'b1;
        idle_inputs();
        cycle();
        frame(1'b1, 4'b0110, 4'h6, "after_rst");

        // start held high: A then 5, pulses five cycles apart
        enable = 1'b1;
        start = 1'b1;
        msb_first = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sin = (i < 4) ? ((4'b1010 >> (3 - i)) & 1'b1)
                : (i >= 5 && i < 9) ? ((4'b0101 >> (8 - i)) & 1'b1)
                : 1'b1;
            cycle();
            if (i == 3) chk("held_a", 32'(out), 32'hA);
            if (i == 8) chk("held_5", 32'(out), 32'h5);
            if (i == 9) start = 1'b0;
        end
        chk("held_gap", 32'(last_valid - prev_valid), 32'd5);
        idle_inputs();
        cycle();

        // msb_first flips after the first bit
        enable = 1'b1;
        start = 1'b1;
        msb_first = 1'b1;
        sin = 1'b1;
        cycle();
        start = 1'b0;
        msb_first = 1'b0;
        sin = 1'b0;
        repeat (3) cycle();
        chk("order_latch", 32'(out), 32'h8);
        idle_inputs();
        cycle();

        // Random traffic with occasional async reset
        for (int n = 0; n < 3000; n++) begin
            enable = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 2) == 0);
            msb_first = 1'($urandom_range(0, 1));
            sin = 1'($urandom_range(0, 1));
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 99) == 0) rst = 1'b0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
